// File: rtl/monitor_pkg.sv
// Shared sizing defaults and drain FSM state encoding for the cluster-0 report collector.
package monitor_pkg;
    localparam int N_REPORTS   = 44;
    localparam int TS_W        = 32;
    localparam int FIFO_DEPTH  = 8;
    localparam int REPORT_ID_W = 6;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } drain_state_e;
endpackage

// File: rtl/report_fifo.sv
// Synchronous FIFO holding {timestamp, report vector} entries; head is presented combinationally.
module report_fifo #(
    parameter int WIDTH = 76,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push    = i_wr_en && !o_full;
    assign w_pop     = i_rd_en && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr];

    // Storage carries no reset; validity is tracked solely by the occupancy count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/report_collector_c0.sv
// Timestamps non-zero report vectors, buffers them and serialises each set bit as one id/ts event.
module report_collector_c0 #(
    parameter int N_REPORTS  = monitor_pkg::N_REPORTS,
    parameter int TS_W       = monitor_pkg::TS_W,
    parameter int FIFO_DEPTH = monitor_pkg::FIFO_DEPTH
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                run,
    input  logic                                stream_reset,
    input  logic [N_REPORTS-1:0]                report_vec,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [monitor_pkg::REPORT_ID_W-1:0] out_id,
    output logic [TS_W-1:0]                     out_ts,
    output logic                                overflow,
    output logic [7:0]                          drop_cnt
);
    import monitor_pkg::*;

    localparam int FW = TS_W + N_REPORTS;

    drain_state_e           r_state;
    drain_state_e           w_next_state;
    logic [TS_W-1:0]        r_ts;
    logic [N_REPORTS-1:0]   r_work_vec;
    logic [TS_W-1:0]        r_work_ts;
    logic                   r_overflow;
    logic [7:0]             r_drop_cnt;

    logic                   w_push_req;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_drop;
    logic                   w_pop;
    logic                   w_fire;
    logic [FW-1:0]          w_head;
    logic [N_REPORTS-1:0]   w_remaining;
    logic [REPORT_ID_W-1:0] w_lsb_id;

    function automatic logic [REPORT_ID_W-1:0] lowest_set(input logic [N_REPORTS-1:0] v);
        logic [REPORT_ID_W-1:0] id;
        id = '0;
        for (int i = N_REPORTS - 1; i >= 0; i--) begin
            if (v[i]) id = REPORT_ID_W'(i);
        end
        return id;
    endfunction

    assign w_push_req  = run && (|report_vec);
    assign w_drop      = w_push_req && w_full;
    assign w_pop       = (r_state == IDLE) && !w_empty;
    assign w_fire      = out_valid && out_ready;
    assign w_lsb_id    = lowest_set(r_work_vec);
    assign w_remaining = r_work_vec & (r_work_vec - N_REPORTS'(1));

    report_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_push_req),
        .i_wr_data ({r_ts, report_vec}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_empty   (w_empty),
        .o_full    (w_full)
    );

    // Symbol timestamp: stream_reset restarts it, but the current symbol still captures the old value.
    always_ff @(posedge clk) begin
        if (reset || stream_reset) begin
            r_ts <= '0;
        end else if (run) begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (!w_empty) w_next_state = EMIT;
            EMIT:    if (w_fire && (w_remaining == '0)) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (r_state == EMIT);
        out_id    = out_valid ? w_lsb_id  : '0;
        out_ts    = out_valid ? r_work_ts : '0;
    end

    // Working vector: loaded on pop, one bit retired per accepted event.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_work_vec <= '0;
        end else if (w_pop) begin
            r_work_vec <= w_head[N_REPORTS-1:0];
        end else if (w_fire) begin
            r_work_vec <= w_remaining;
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_work_ts <= w_head[FW-1:N_REPORTS];
        end
    end

    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_report_collector_c0.sv
// Directed bench for report_collector_c0: latency, back-pressure, overflow, timestamp restart/wrap, reset.
module tb_report_collector_c0;
    logic        clk = 1'b0;
    logic        reset, run, stream_reset, out_ready;
    logic [43:0] report_vec;
    logic        out_valid, overflow;
    logic [5:0]  out_id;
    logic [31:0] out_ts;
    logic [7:0]  drop_cnt;

    logic        reset4, run4, sr4, ready4;
    logic [43:0] vec4;
    logic        valid4, ovf4;
    logic [5:0]  id4;
    logic [3:0]  ts4;
    logic [7:0]  drop4;

    int n_checks = 0;
    int n_errors = 0;
    int q_id[$];
    int q_ts[$];

    always #5 clk = ~clk;

    report_collector_c0 dut (
        .clk(clk), .reset(reset), .run(run), .stream_reset(stream_reset),
        .report_vec(report_vec), .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_ts(out_ts), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    report_collector_c0 #(.TS_W(4)) dut4 (
        .clk(clk), .reset(reset4), .run(run4), .stream_reset(sr4),
        .report_vec(vec4), .out_valid(valid4), .out_ready(ready4),
        .out_id(id4), .out_ts(ts4), .overflow(ovf4), .drop_cnt(drop4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; stream_reset = 1'b0; report_vec = '0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    // Records every presented event while out_ready=1, for a bounded number of cycles.
    task automatic collect(input int cycles);
        q_id.delete(); q_ts.delete();
        for (int c = 0; c < cycles; c++) begin
            if (out_valid) begin
                q_id.push_back(int'(out_id));
                q_ts.push_back(int'(out_ts));
            end
            tick();
        end
    endtask

    initial begin
        reset4 = 1'b1; run4 = 1'b0; sr4 = 1'b0; vec4 = '0; ready4 = 1'b1;

        // Reset state
        do_reset();
        chk("rst_valid", out_valid, 0);
        chk("rst_id", out_id, 0);
        chk("rst_ts", out_ts, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_cnt, 0);

        // Two-bit report at ts=5, t+2 latency
        out_ready = 1'b1; run = 1'b1;
        repeat (5) tick();
        report_vec = '0; report_vec[3] = 1'b1; report_vec[40] = 1'b1;
        tick();
        report_vec = '0; run = 1'b0;
        chk("lat_t1_valid", out_valid, 0);
        tick();
        chk("lat_t2_valid", out_valid, 1);
        chk("lat_t2_id", out_id, 3);
        chk("lat_t2_ts", out_ts, 5);
        tick();
        chk("ev2_valid", out_valid, 1);
        chk("ev2_id", out_id, 40);
        chk("ev2_ts", out_ts, 5);
        tick();
        chk("bubble_valid", out_valid, 0);
        chk("bubble_id", out_id, 0);

        // Back-pressure holds the event stable
        do_reset();
        run = 1'b1; report_vec = 44'h6;
        tick();
        run = 1'b0; report_vec = '0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_id", out_id, 1);
            chk("hold_ts", out_ts, 0);
            tick();
        end
        out_ready = 1'b1;
        chk("hold_last_id", out_id, 1);
        tick();
        chk("after_ready_id", out_id, 2);
        chk("after_ready_valid", out_valid, 1);
        tick();
        chk("after_ready_idle", out_valid, 0);

        // Overflow: one vector held in EMIT, then 10 more -> 8 buffered, 2 dropped
        do_reset();
        run = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            report_vec = '0; report_vec[k] = 1'b1;
            if (k == 9) chk("ovf_before", overflow, 0);
            tick();
        end
        run = 1'b0; report_vec = '0;
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop", drop_cnt, 2);
        chk("ovf_head_id", out_id, 0);
        out_ready = 1'b1;
        collect(40);
        chk("ovf_n_events", q_id.size(), 9);
        for (int i = 0; i < q_id.size() && i < 9; i++) begin
            chk("ovf_ev_id", q_id[i], i);
            chk("ovf_ev_ts", q_ts[i], i);
        end
        chk("ovf_sticky", overflow, 1);

        // stream_reset at ts=100 restarts the timestamp after capturing 100
        do_reset();
        out_ready = 1'b1; run = 1'b1;
        repeat (100) tick();
        stream_reset = 1'b1; report_vec = '0; report_vec[5] = 1'b1;
        tick();
        stream_reset = 1'b0; report_vec = '0; report_vec[7] = 1'b1;
        tick();
        run = 1'b0; report_vec = '0;
        collect(20);
        chk("sr_n_events", q_id.size(), 2);
        if (q_id.size() == 2) begin
            chk("sr_ev0_id", q_id[0], 5);
            chk("sr_ev0_ts", q_ts[0], 100);
            chk("sr_ev1_id", q_id[1], 7);
            chk("sr_ev1_ts", q_ts[1], 0);
        end

        // Reset mid-EMIT with 3 bits pending and one vector queued
        do_reset();
        run = 1'b1; report_vec = 44'h54;
        tick();
        report_vec = '0; report_vec[9] = 1'b1;
        tick();
        run = 1'b0; report_vec = '0;
        chk("mid_valid", out_valid, 1);
        chk("mid_id", out_id, 2);
        tick();
        reset = 1'b1; out_ready = 1'b1; run = 1'b1; report_vec = 44'h2;
        tick();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_id", out_id, 0);
        chk("mid_rst_ts", out_ts, 0);
        reset = 1'b0; run = 1'b0; report_vec = '0;
        collect(15);
        chk("mid_rst_no_events", q_id.size(), 0);

        // 4-bit timestamp wraps after 16 run cycles
        tick();
        reset4 = 1'b0; run4 = 1'b1;
        repeat (16) tick();
        vec4 = '0; vec4[1] = 1'b1;
        tick();
        run4 = 1'b0; vec4 = '0;
        chk("wrap_t1_valid", valid4, 0);
        tick();
        chk("wrap_valid", valid4, 1);
        chk("wrap_id", id4, 1);
        chk("wrap_ts", ts4, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
